conv_output_event_unpacker: RTL

//  Receiving end of the convolution/pooling output stream. Accepts one packed output_vector_t
//  (timestep, x, y, per-out-channel spike vector) per handshake and serialises it into

---
 rtl/conv_output_event_unpacker_pkg.sv | 33 +++
 rtl/conv_output_event_unpacker_if.sv | 22 ++
 rtl/conv_output_event_unpacker_spike_priority_encoder.sv | 20 ++
 rtl/conv_output_event_unpacker.sv | 125 ++++++++++++
 4 files changed

// File: rtl/conv_output_event_unpacker_pkg.sv
// Shared types for the conv output stream and the single-spike event unpacker.
// Optional feature macro: TIMESTEP_MARKER_EN (timestep-change marker events).
package conv_output_event_unpacker_pkg;

  localparam int OUT_CHANNELS  = 2;
  localparam int COORD_BITS    = 2;
  localparam int TIMESTEP_BITS = 8;
  localparam int CH_BITS       = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1;

  typedef logic [OUT_CHANNELS-1:0] spike_vector_out_t;

  typedef struct packed {
    logic [TIMESTEP_BITS-1:0] timestep;
    logic [COORD_BITS-1:0]    x;
    logic [COORD_BITS-1:0]    y;
    spike_vector_out_t        spikes;
  } output_vector_t;

  typedef struct packed {
    logic                     marker;
    logic [TIMESTEP_BITS-1:0] timestep;
    logic [COORD_BITS-1:0]    x;
    logic [COORD_BITS-1:0]    y;
    logic [CH_BITS-1:0]       channel;
  } unpacked_event_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    MARK = 2'd2
  } unpacker_state_t;

endpackage

// File: rtl/conv_output_event_unpacker_if.sv
// Packed-vector input stream and single-event output stream of the unpacker.
// master = side driving vectors in and taking events out; slave = the unpacker.
interface conv_output_event_unpacker_if;
  import conv_output_event_unpacker_pkg::*;

  logic            in_valid;
  logic            in_ready;
  output_vector_t  in_vec;
  logic            out_valid;
  logic            out_ready;
  unpacked_event_t out_event;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_event
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_event
  );
endinterface

// File: rtl/conv_output_event_unpacker_spike_priority_encoder.sv
// Combinational lowest-set-bit finder: pend -> {any, lowest_idx}.
module spike_priority_encoder #(
  parameter int OUT_CHANNELS = 2,
  parameter int IDX_BITS     = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1
) (
  input  logic [OUT_CHANNELS-1:0] pend,
  output logic                    any,
  output logic [IDX_BITS-1:0]     lowest_idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    any        = |pend;
    lowest_idx = '0;
    for (int i = OUT_CHANNELS - 1; i >= 0; i--) begin
      if (pend[i]) lowest_idx = IDX_BITS'(i);
    end
  end

endmodule

// File: rtl/conv_output_event_unpacker.sv
// Serialises one packed conv output vector into one event per set spike bit,
// channel 0 first. Build option: TIMESTEP_MARKER_EN inserts a marker event
// whenever an accepted vector carries a new timestep.
module conv_output_event_unpacker
  import conv_output_event_unpacker_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  conv_output_event_unpacker_if.slave  bus,
  output logic                         busy
);

  unpacker_state_t          state_reg, state_next;
  spike_vector_out_t        pend_reg, pend_next;
  logic [TIMESTEP_BITS-1:0] ts_reg, ts_next;
  logic [COORD_BITS-1:0]    x_reg, x_next;
  logic [COORD_BITS-1:0]    y_reg, y_next;
`ifdef TIMESTEP_MARKER_EN
  logic [TIMESTEP_BITS-1:0] prev_ts_reg, prev_ts_next;
`endif

  logic                     pend_any;
  logic [CH_BITS-1:0]       pend_idx;
  spike_vector_out_t        clear_mask;

  spike_priority_encoder #(
    .OUT_CHANNELS (OUT_CHANNELS),
    .IDX_BITS     (CH_BITS)
  ) u_enc (
    .pend       (pend_reg),
    .any        (pend_any),
    .lowest_idx (pend_idx)
  );

  assign clear_mask = spike_vector_out_t'(1) << pend_idx;

  // State and latched vector registers; reset drops any pending spikes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      pend_reg    <= '0;
      ts_reg      <= '0;
      x_reg       <= '0;
      y_reg       <= '0;
`ifdef TIMESTEP_MARKER_EN
      prev_ts_reg <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      pend_reg    <= pend_next;
      ts_reg      <= ts_next;
      x_reg       <= x_next;
      y_reg       <= y_next;
`ifdef TIMESTEP_MARKER_EN
      prev_ts_reg <= prev_ts_next;
`endif
    end
  end

  // Next-state logic: accept in IDLE, retire one spike bit per output handshake.
  always_comb begin
    state_next   = state_reg;
    pend_next    = pend_reg;
    ts_next      = ts_reg;
    x_next       = x_reg;
    y_next       = y_reg;
`ifdef TIMESTEP_MARKER_EN
    prev_ts_next = prev_ts_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          ts_next   = bus.in_vec.timestep;
          x_next    = bus.in_vec.x;
          y_next    = bus.in_vec.y;
          pend_next = bus.in_vec.spikes;
`ifdef TIMESTEP_MARKER_EN
          prev_ts_next = bus.in_vec.timestep;
          if (bus.in_vec.timestep != prev_ts_reg) state_next = MARK;
          else if (|bus.in_vec.spikes)            state_next = EMIT;
`else
          if (|bus.in_vec.spikes) state_next = EMIT;
`endif
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          pend_next = pend_reg & ~clear_mask;
          if (pend_next == '0) state_next = IDLE;
        end
      end
`ifdef TIMESTEP_MARKER_EN
      MARK: begin
        if (bus.out_ready) state_next = pend_any ? EMIT : IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode straight from state so an async reset clears them at once.
  always_comb begin
    bus.in_ready  = (state_reg == IDLE);
    bus.out_valid = (state_reg != IDLE);
    busy          = (state_reg != IDLE);
    bus.out_event = '0;
    case (state_reg)
      EMIT: begin
        bus.out_event.marker   = 1'b0;
        bus.out_event.timestep = ts_reg;
        bus.out_event.x        = x_reg;
        bus.out_event.y        = y_reg;
        bus.out_event.channel  = pend_idx;
      end
`ifdef TIMESTEP_MARKER_EN
      MARK: begin
        bus.out_event.marker   = 1'b1;
        bus.out_event.timestep = ts_reg;
      end
`endif
      default: bus.out_event = '0;
    endcase
  end

endmodule
